// File: rtl/pipe_packer.sv
// pipe_packer: packs `ratio` beats of `width` bits into one word, first beat
// in the LSB lane. A registered output word is handed over with an
// enable/ready handshake. Only the final beat of a word waits on the output
// side; non-final beats always accumulate.
// Optional feature macro: PIPE_PACKER_FLUSH_EN adds flush__ENA/flush__RDY,
// which emit a partial word with its unwritten lanes zeroed, and out_lanes,
// which reports the number of valid lanes in the current output word.
module pipe_packer #(
  parameter int unsigned width = 32,
  parameter int unsigned ratio = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
`ifdef PIPE_PACKER_FLUSH_EN
  input  logic                       flush__ENA,
  output logic                       flush__RDY,
  output logic [$clog2(ratio):0]     out_lanes,
`endif
  input  logic                       in_enq__ENA,
  input  logic [width-1:0]           in_enq_v,
  output logic                       in_enq__RDY,
  output logic                       out_enq__ENA,
  output logic [width*ratio-1:0]     out_enq_v,
  input  logic                       out_enq__RDY
);

  localparam int unsigned CW = $clog2(ratio);
  localparam int unsigned OW = width * ratio;
  localparam logic [CW-1:0] LAST = CW'(ratio - 1);

  logic [OW-1:0] acc, acc_n;
  logic [OW-1:0] obuf, obuf_n;
  logic [OW-1:0] merged;
  logic [CW-1:0] cnt, cnt_n;
  logic          ovalid, ovalid_n;
  logic          last;
  logic          accept;

`ifdef PIPE_PACKER_FLUSH_EN
  logic [CW:0]   lanes, lanes_n;
  logic [CW:0]   fill;
  logic [OW-1:0] masked;
  logic          flush_fire;
`endif

  // Handshake terms: only the final beat depends on the output side.
  assign last         = (cnt == LAST);
  assign in_enq__RDY  = last ? (!ovalid || out_enq__RDY) : 1'b1;
  assign accept       = in_enq__ENA && in_enq__RDY;
  assign out_enq__ENA = ovalid && out_enq__RDY;
  assign out_enq_v    = obuf;

  // Accumulator with the incoming beat placed in lane cnt.
  always_comb begin
    merged = acc;
    for (int unsigned i = 0; i < ratio; i++) begin
      if (cnt == CW'(i)) begin
        merged[i*width +: width] = in_enq_v;
      end
    end
  end

`ifdef PIPE_PACKER_FLUSH_EN
  assign flush__RDY = (cnt != '0) && (!ovalid || out_enq__RDY);
  assign flush_fire = flush__ENA && flush__RDY;
  assign out_lanes  = lanes;
  assign fill       = {1'b0, cnt} + {{CW{1'b0}}, accept};

  // Flushed word: lanes written so far (including a same-cycle beat), rest zeroed.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < ratio; i++) begin
      if ((CW+1)'(i) < fill) begin
        masked[i*width +: width] = merged[i*width +: width];
      end
    end
  end
`endif

  // Next-state: drain clears ovalid, a load in the same cycle sets it again.
  always_comb begin
    acc_n    = acc;
    cnt_n    = cnt;
    obuf_n   = obuf;
    ovalid_n = ovalid;
`ifdef PIPE_PACKER_FLUSH_EN
    lanes_n  = lanes;
`endif
    if (out_enq__ENA) begin
      ovalid_n = 1'b0;
    end
    if (accept) begin
      acc_n = merged;
      if (last) begin
        obuf_n   = merged;
        ovalid_n = 1'b1;
        cnt_n    = '0;
`ifdef PIPE_PACKER_FLUSH_EN
        lanes_n  = (CW+1)'(ratio);
`endif
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
`ifdef PIPE_PACKER_FLUSH_EN
    // A flush together with a final beat gives fill == ratio, so masked equals merged.
    if (flush_fire) begin
      obuf_n   = masked;
      ovalid_n = 1'b1;
      cnt_n    = '0;
      lanes_n  = fill;
    end
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc    <= '0;
      cnt    <= '0;
      obuf   <= '0;
      ovalid <= 1'b0;
`ifdef PIPE_PACKER_FLUSH_EN
      lanes  <= '0;
`endif
    end else begin
      acc    <= acc_n;
      cnt    <= cnt_n;
      obuf   <= obuf_n;
      ovalid <= ovalid_n;
`ifdef PIPE_PACKER_FLUSH_EN
      lanes  <= lanes_n;
`endif
    end
  end

endmodule

// File: doc/pipe_packer.md
PIPE_PACKER -- requirements
Module: pipe_packer

Interface
REQ-001 Parameter: width, default 32, bit width of one input beat.
REQ-002 Parameter: ratio, default 4, input beats per output word; legal range 2..16.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  synchronous, active-high reset.
REQ-005 Port: in_enq__ENA  input  1  upstream enqueue strobe; upstream asserts it only while in_enq__RDY=1.
REQ-006 Port: in_enq_v  input  width  beat data, valid when in_enq__ENA=1.
REQ-007 Port: in_enq__RDY  output  1  packer can accept a beat this cycle.
REQ-008 Port: out_enq__ENA  output  1  packed word offered and taken this cycle; asserted only while out_enq__RDY=1.
REQ-009 Port: out_enq_v  output  width*ratio  packed word.
REQ-010 Port: out_enq__RDY  input  1  downstream (e.g. one-entry FIFO enq side) can accept.

Function
REQ-011 Internal state: accumulator acc[width*ratio], beat counter cnt[clog2(ratio)], output register obuf[width*ratio], flag ovalid.
REQ-012 Lane order: beat k (k=0 first) occupies bits [k*width +: width]; first beat lands in LSBs.
REQ-013 Beat accepted when in_enq__ENA=1 and in_enq__RDY=1; data written to lane cnt of acc.
REQ-014 Non-final beat (cnt<ratio-1): cnt increments; in_enq__RDY=1 regardless of ovalid.
REQ-015 Final beat (cnt=ratio-1): in_enq__RDY = !ovalid || out_enq__RDY; on accept, obuf <= acc with new lane merged, ovalid <= 1, cnt <= 0.
REQ-016 out_enq__ENA = ovalid && out_enq__RDY; out_enq_v = obuf at all times.
REQ-017 out_enq__ENA with no new word loaded clears ovalid next cycle; drain and load in the same cycle leave ovalid=1 with the new word (full throughput, one word per ratio beats).
REQ-018 Latency: word becomes visible on out_enq_v the cycle after its final beat is accepted.
REQ-019 in_enq__RDY depends combinationally on out_enq__RDY only in the final-beat case; there is no path from in_enq__ENA to any RDY output.
REQ-020 Lanes of acc not yet written in the current word are don't-care; output lanes are always fully written (unless REQ-027 applies).
REQ-021 Downstream stall: non-final beats continue to accumulate; only the final beat stalls.

Reset
REQ-022 RST=1 at a clock edge: cnt <= 0, ovalid <= 0, acc <= 0, obuf <= 0.
REQ-023 While RST=1 and on the cycle after release: out_enq__ENA=0, out_enq_v=0, in_enq__RDY=1.
REQ-024 Reset mid-word discards the partial word and any unsent obuf content; no partial word is emitted.

Configuration
REQ-025 Macro PIPE_PACKER_FLUSH_EN compiles in the flush feature; without it, the ports in REQ-026 and REQ-029 are absent and the block behaves as REQ-011..REQ-024 only.
REQ-026 With the macro: ports flush__ENA input 1, flush__RDY output 1.
REQ-027 flush__RDY = (cnt!=0) && (!ovalid || out_enq__RDY); on flush, obuf <= accumulated lanes with unwritten lanes zeroed, ovalid <= 1, cnt <= 0.
REQ-028 Flush and beat accepted in the same cycle: the beat is merged at lane cnt first, then the word is emitted as in REQ-027.
REQ-029 With the macro: port out_lanes output clog2(ratio)+1 gives the valid lane count of obuf (ratio for a full word); its reset value is 0.

Verification
REQ-030 width=8, ratio=4: beats 0x11,0x22,0x33,0x44 with out_enq__RDY=1 -> one cycle later out_enq__ENA=1, out_enq_v=0x44332211.
REQ-031 Continuous beats 0x00..0x0B with RDY=1 -> 3 words 0x03020100, 0x07060504, 0x0B0A0908 with no input stall.
REQ-032 out_enq__RDY=0 after the first word: next 3 beats accepted, 4th beat sees in_enq__RDY=0; RDY=1 -> first word drains and 4th beat is accepted in the same cycle.
REQ-033 RST asserted after 2 beats -> cnt=0, no output; then beats 0xA1..0xA4 -> out_enq_v=0xA4A3A2A1.
REQ-034 FLUSH_EN: beats 0x55,0x66 then flush__ENA -> out_enq_v=0x00006655, out_lanes=2; flush__RDY=0 when cnt=0.
REQ-035 FLUSH_EN: flush__ENA with beat 0x77 at cnt=1 (lane 0=0x55) -> out_enq_v=0x00007755, out_lanes=2.
